// File: rtl/io_input_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_input_feeder : FIFO-buffered producer for the memory-mapped input port
// Rev 1.0
// ---------------------------------------------------------------------------
module io_input_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [15:0]              DevData,
  input  logic                     DevValid,
  output logic                     DevReady,
  output logic [15:0]              Input,
  output logic                     InputStrobe,
  input  logic                     InputRecv,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     TimeoutErr,
  input  logic                     ErrClr
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DELIVER = 2'd1;
  localparam logic [1:0] S_PENDING = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [15:0]      r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             r_live;
  logic [15:0]      r_input;
  logic [CNT_W-1:0] r_timer;
  logic             r_err;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_load;
  logic             w_strobe;
  logic             w_wait;
  logic             w_timeout;

  // r_live keeps DevReady low while reset is asserted
  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign DevReady  = r_live && !w_full;
  assign w_push    = DevValid && DevReady;
  assign w_pop     = (r_state == S_DELIVER);
  assign w_timeout = w_wait && (r_timer == CNT_W'(TIMEOUT));

  assign Input       = r_input;
  assign InputStrobe = w_strobe;
  assign Count       = r_count;
  assign TimeoutErr  = r_err;

  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wptr] <= DevData;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (r_count != '0 && !InputRecv) w_next = S_DELIVER;
      S_DELIVER: w_next = S_PENDING;
      S_PENDING: if (InputRecv) w_next = S_DRAIN;
      S_DRAIN:   if (!InputRecv) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_strobe = (r_state == S_DELIVER);
    w_wait   = (r_state == S_PENDING) || (r_state == S_DRAIN);
    w_load   = (r_state == S_IDLE) && (w_next == S_DELIVER);
  end

  // Head is captured on entry to DELIVER so Input is valid during the strobe
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_input <= 16'h0000;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_load) r_input <= r_mem[r_rptr];
      if (r_state == S_DELIVER || (r_state == S_PENDING && InputRecv))
        r_timer <= '0;
      else if (w_wait && !w_timeout)
        r_timer <= r_timer + 1'b1;
      if (w_timeout)   r_err <= 1'b1;
      else if (ErrClr) r_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire
